// File: rtl/seg_scan_capture.sv
// seg_scan_capture: samples a multiplexed 7-segment scan and rebuilds the displayed 16-bit word.
module seg_scan_capture #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter bit SEG_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg_output_single,
  input  logic [3:0]  seg_output_sequence,
  input  logic [3:0]  led_output,
  output logic [15:0] word,
  output logic [3:0]  tag,
  output logic        word_valid,
  output logic        word_changed,
  output logic        digit_err,
  output logic        frame_err
);
  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
  state_t      state;
  logic [7:0]  seg_r, sc;
  logic [3:0]  sel_r, led_r, cur_sel, mask, tag_sh;
  logic [15:0] shadow, tcnt;
  logic [6:0]  seg;
  logic [3:0]  sel, nib;
  logic [1:0]  idx;
  logic        sel_ok, nib_ok, sample, dec_ok;
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_r <= '0;
      sel_r <= '0;
      led_r <= '0;
    end else begin
      seg_r <= seg_output_single;
      sel_r <= seg_output_sequence;
      led_r <= led_output;
    end
  end
  assign seg    = SEG_ACTIVE_LOW ? ~seg_r[6:0] : seg_r[6:0];
  assign sel    = SEG_ACTIVE_LOW ? ~sel_r : sel_r;
  assign sel_ok = $onehot(sel);
  assign idx    = sel[3] ? 2'd3 : sel[2] ? 2'd2 : sel[1] ? 2'd1 : 2'd0;
  // the cycle that completes the settle window is itself counted
  assign sample = state == SETTLE && sel_ok && sel == cur_sel &&
                  ({1'b0, sc} + 9'd1 >= 9'(SETTLE_CYCLES));
  assign dec_ok = sample && nib_ok;
  always_comb begin
    nib    = '0;
    nib_ok = 1'b1;
    case (seg)
      7'h3F: nib = 4'h0;
      7'h06: nib = 4'h1;
      7'h5B: nib = 4'h2;
      7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;
      7'h6D: nib = 4'h5;
      7'h7D: nib = 4'h6;
      7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h6F: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h7C: nib = 4'hB;
      7'h39: nib = 4'hC;
      7'h5E: nib = 4'hD;
      7'h79: nib = 4'hE;
      7'h71: nib = 4'hF;
      default: nib_ok = 1'b0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sc      <= '0;
      cur_sel <= '0;
    end else if (!sel_ok) begin
      state <= IDLE;
      sc    <= '0;
    end else if (state == IDLE || sel != cur_sel) begin
      state   <= SETTLE;
      sc      <= 8'd1;
      cur_sel <= sel;
    end else if (state == SETTLE) begin
      state <= sample ? HOLD : SETTLE;
      sc    <= (sc == 8'hFF) ? sc : sc + 8'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow       <= '0;
      mask         <= '0;
      tcnt         <= '0;
      tag_sh       <= '0;
      word         <= '0;
      tag          <= '0;
      word_valid   <= 1'b0;
      word_changed <= 1'b0;
      digit_err    <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      word_valid   <= 1'b0;
      word_changed <= 1'b0;
      frame_err    <= 1'b0;
      digit_err    <= sample && !nib_ok;
      if (mask == 4'hF) begin
        word         <= shadow;
        tag          <= tag_sh;
        word_valid   <= 1'b1;
        word_changed <= shadow != word;
        mask         <= '0;
        tcnt         <= '0;
      end else if (dec_ok) begin
        shadow[{idx, 2'b00} +: 4] <= nib;
        mask[idx]                 <= 1'b1;
        tag_sh                    <= led_r;
        tcnt                      <= '0;
      end else if (mask != '0) begin
        if (tcnt >= 16'(TIMEOUT_CYCLES)) begin
          frame_err <= 1'b1;
          mask      <= '0;
          tcnt      <= '0;
        end else begin
          tcnt <= tcnt + 16'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture: table vectors, corner sequences and a dwell-level random model.
module tb_seg_scan_capture;
  localparam int S = 4;
  localparam int T = 10000;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  seg_output_single = 8'hFF;
  logic [3:0]  seg_output_sequence = 4'hF;
  logic [3:0]  led_output = 4'h0;
  logic [15:0] word;
  logic [3:0]  tag;
  logic        word_valid, word_changed, digit_err, frame_err;
  seg_scan_capture dut (
    .clk(clk), .rst(rst),
    .seg_output_single(seg_output_single),
    .seg_output_sequence(seg_output_sequence),
    .led_output(led_output),
    .word(word), .tag(tag),
    .word_valid(word_valid), .word_changed(word_changed),
    .digit_err(digit_err), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [15:0] w; logic [3:0] t; logic c;} ev_t;
  typedef struct {logic [15:0] val; logic [3:0] led; logic chg;} vec_t;
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [3:0] bad [4] = '{4'hF, 4'h0, 4'b0011, 4'b0101};
  ev_t evq[$];
  ev_t exq[$];
  int  n_valid = 0, n_derr = 0, n_ferr = 0;
  int  n_tests = 0, n_fail = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (word_valid) begin
        evq.push_back({word, tag, word_changed});
        n_valid++;
      end
      if (digit_err) n_derr++;
      if (frame_err) n_ferr++;
    end
  end
  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction
  function automatic int lookup(logic [6:0] s);
    for (int i = 0; i < 16; i++) if (seg_tab[i] == s) return i;
    return -1;
  endfunction
  task automatic dwell(input logic [3:0] raw_sel, input logic [7:0] raw_seg, input int len);
    seg_output_sequence = raw_sel;
    seg_output_single   = raw_seg;
    repeat (len) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic digit(input int i, input logic [3:0] n, input int len);
    dwell(~(4'b0001 << i), {1'b1, ~seg_tab[n]}, len);
  endtask
  task automatic scan(input logic [15:0] v, input int len);
    for (int i = 3; i >= 0; i--) digit(i, v[i*4 +: 4], len);
    dwell(4'hF, 8'hFF, 4);
  endtask
  vec_t tab [5];
  initial begin
    int v0, d0, f0, base, mmask, idx, len, k, ok;
    logic [15:0] shadow, prev;
    logic [3:0] raw, prev_raw, led;
    logic [6:0] s7;
    logic dp, vld;
    tab[0] = '{16'h3C7F, 4'hA, 1'b1};
    tab[1] = '{16'h3C7F, 4'hA, 1'b0};
    tab[2] = '{16'h89AB, 4'h3, 1'b1};
    tab[3] = '{16'hDE56, 4'hF, 1'b1};
    tab[4] = '{16'h0000, 4'h0, 1'b1};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_word", word, 0);
    check("reset_tag", tag, 0);
    check("reset_pulses", {word_valid, word_changed, digit_err, frame_err}, 0);
    for (int i = 0; i < 5; i++) begin
      v0 = n_valid;
      d0 = n_derr;
      led_output = tab[i].led;
      scan(tab[i].val, 8);
      check($sformatf("vec%0d_valid", i), n_valid - v0, 1);
      check($sformatf("vec%0d_derr", i), n_derr - d0, 0);
      check($sformatf("vec%0d_word", i), word, tab[i].val);
      if (n_valid > v0) begin
        check($sformatf("vec%0d_ev_word", i), evq[$].w, tab[i].val);
        check($sformatf("vec%0d_tag", i), evq[$].t, tab[i].led);
        check($sformatf("vec%0d_chg", i), evq[$].c, tab[i].chg);
      end
    end
    v0 = n_valid; d0 = n_derr; f0 = n_ferr;
    scan(16'h1357, 3);
    check("short_valid", n_valid - v0, 0);
    check("short_derr", n_derr - d0, 0);
    check("short_ferr", n_ferr - f0, 0);
    check("short_word", word, 0);
    v0 = n_valid; d0 = n_derr;
    digit(3, 4'h1, 8);
    dwell(4'b1011, 8'hFF, 8);
    digit(1, 4'h2, 8);
    dwell(4'b1011, 8'hFF, 8);
    digit(0, 4'h3, 8);
    dwell(4'hF, 8'hFF, 4);
    check("blank_derr", n_derr - d0, 2);
    check("blank_valid", n_valid - v0, 0);
    f0 = n_ferr;
    for (int i = 0; i < T + 100 && n_ferr == f0; i++) @(posedge clk);
    #1;
    check("blank_timeout", n_ferr - f0, 1);
    f0 = n_ferr;
    led_output = 4'h7;
    digit(3, 4'h1, 8);
    digit(2, 4'h2, 8);
    dwell(4'hF, 8'hFF, T);
    for (int i = 0; i < 100 && n_ferr == f0; i++) @(posedge clk);
    #1;
    check("timeout_ferr", n_ferr - f0, 1);
    dwell(4'hF, 8'hFF, 20);
    check("timeout_single", n_ferr - f0, 1);
    v0 = n_valid;
    scan(16'h1234, 8);
    check("after_to_valid", n_valid - v0, 1);
    check("after_to_word", word, 16'h1234);
    check("after_to_tag", tag, 4'h7);
    digit(3, 4'h9, 8);
    digit(2, 4'h9, 8);
    digit(1, 4'h9, 8);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_word", word, 0);
    check("rst_tag", tag, 0);
    check("rst_pulses", {word_valid, word_changed, digit_err, frame_err}, 0);
    v0 = n_valid; d0 = n_derr; f0 = n_ferr;
    dwell(4'hF, 8'hFF, 20);
    check("rst_quiet", (n_valid - v0) + (n_derr - d0) + (n_ferr - f0), 0);
    led_output = 4'hC;
    scan(16'hA5C3, 8);
    check("rst_scan_valid", n_valid - v0, 1);
    check("rst_scan_word", word, 16'hA5C3);
    if (n_valid > v0) check("rst_scan_chg", evq[$].c, 1);
    base = evq.size();
    d0 = n_derr;
    mmask = 0;
    shadow = '0;
    prev = 16'hA5C3;
    prev_raw = 4'hF;
    k = 0;
    for (int n = 0; n < 400; n++) begin
      do begin
        vld = $urandom_range(9) < 8;
        idx = $urandom_range(3);
        raw = vld ? ~(4'b0001 << idx) : bad[$urandom_range(3)];
      end while (raw == prev_raw);
      prev_raw = raw;
      s7  = ($urandom_range(9) < 8) ? seg_tab[$urandom_range(15)] : 7'($urandom);
      dp  = 1'($urandom);
      len = $urandom_range(1, 10);
      led = 4'($urandom);
      led_output = led;
      dwell(raw, ~{dp, s7}, len);
      if (vld && len >= S) begin
        ok = lookup(s7);
        if (ok < 0) k++;
        else begin
          shadow[idx*4 +: 4] = 4'(ok);
          mmask |= 1 << idx;
          if (mmask == 15) begin
            exq.push_back({shadow, led, shadow != prev});
            prev = shadow;
            mmask = 0;
          end
        end
      end
    end
    dwell(4'hF, 8'hFF, 8);
    check("rand_count", evq.size() - base, exq.size());
    check("rand_derr", n_derr - d0, k);
    for (int i = 0; i < exq.size() && base + i < evq.size(); i++)
      check($sformatf("rand_ev%0d", i), evq[base + i], exq[i]);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
